// File: rtl/cdb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared types and constants for the common-data-bus (CDB) stage. The RS and
// RAT snoop ports reuse cdb_bus_t so every consumer sees the same layout.
//   BITWIDTH  : result data width
//   NRALUOP   : number of functional units / result ports
//   RS_DEPTH  : reservation-station entries per FU
//   BUF_DEPTH : result FIFO depth per FU
// ---------------------------------------------------------------------------
package cdb_arbiter_pkg;

    localparam int BITWIDTH  = 32;
    localparam int NRALUOP   = 8;
    localparam int RS_DEPTH  = 8;
    localparam int BUF_DEPTH = 2;

    // Tag = {FU id, RS slot}
    function automatic int tag_w(input int n_fu, input int rs_depth);
        return $clog2(n_fu) + $clog2(rs_depth);
    endfunction

    localparam int TAG_W = tag_w(NRALUOP, RS_DEPTH);
    localparam int FU_W  = $clog2(NRALUOP);

    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [BITWIDTH-1:0] data;
    } cdb_entry_t;

    typedef struct packed {
        logic                valid;
        logic [FU_W-1:0]     fu;
        logic [TAG_W-1:0]    tag;
        logic [BITWIDTH-1:0] data;
    } cdb_bus_t;

endpackage

// File: rtl/cdb_arbiter_result_fifo.sv
// ---------------------------------------------------------------------------
// result_fifo
// Small per-FU result FIFO. The head entry is read asynchronously because
// the arbiter must see it in the same cycle it decides the grant.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push/din : write din at the tail (caller never pushes when full)
//   pop/dout : dout is the current head; pop drops it (caller never pops
//              when empty)
//   empty    : no entries
//   full     : DEPTH entries
// ---------------------------------------------------------------------------
module result_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 38
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so a full FIFO is distinguishable from an empty one
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        head_d  = pop  ? next_ptr(head_q) : head_q;
        tail_d  = push ? next_ptr(tail_q) : tail_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[tail_q] <= din;
        end
    end

    assign dout  = mem[head_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
// Buffers one result stream per functional unit and broadcasts one result per
// cycle on a registered common data bus, chosen round-robin.
//   clk, rst   : clock, synchronous active-high reset
//   fu_valid   : FU i presents a result
//   fu_tag     : tag {FU id, RS slot} of FU i's result
//   fu_data    : value of FU i's result
//   fu_ready   : FIFO i can accept (transfer on fu_valid & fu_ready)
//   cdb_valid  : one-cycle broadcast pulse (registered)
//   cdb_tag    : broadcast tag (registered, held when idle)
//   cdb_data   : broadcast value (registered, held when idle)
//   cdb_fu     : granted FU index (registered, held when idle)
// ---------------------------------------------------------------------------
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int P_BITWIDTH  = BITWIDTH,
    parameter int P_NRALUOP   = NRALUOP,
    parameter int P_RS_DEPTH  = RS_DEPTH,
    parameter int P_BUF_DEPTH = BUF_DEPTH,
    parameter int P_TAG_W     = tag_w(P_NRALUOP, P_RS_DEPTH),
    parameter int P_FU_W      = $clog2(P_NRALUOP)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [P_NRALUOP-1:0]                fu_valid,
    input  logic [P_NRALUOP-1:0][P_TAG_W-1:0]   fu_tag,
    input  logic [P_NRALUOP-1:0][P_BITWIDTH-1:0] fu_data,
    output logic [P_NRALUOP-1:0]                fu_ready,
    output logic                                cdb_valid,
    output logic [P_TAG_W-1:0]                  cdb_tag,
    output logic [P_BITWIDTH-1:0]               cdb_data,
    output logic [P_FU_W-1:0]                   cdb_fu
);

    localparam int ENTRY_W = P_TAG_W + P_BITWIDTH;

    typedef struct packed {
        logic [P_TAG_W-1:0]    tag;
        logic [P_BITWIDTH-1:0] data;
    } entry_t;

    entry_t                 head_entry [P_NRALUOP];
    logic [P_NRALUOP-1:0]   fifo_empty;
    logic [P_NRALUOP-1:0]   fifo_full;
    logic [P_NRALUOP-1:0]   push;
    logic [P_NRALUOP-1:0]   pop;

    logic                   grant_valid;
    logic [P_FU_W-1:0]      grant_idx;

    logic [P_FU_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                   cdb_valid_q, cdb_valid_d;
    logic [P_TAG_W-1:0]     cdb_tag_q, cdb_tag_d;
    logic [P_BITWIDTH-1:0]  cdb_data_q, cdb_data_d;
    logic [P_FU_W-1:0]      cdb_fu_q, cdb_fu_d;

    // Per-FU result buffers
    generate
        for (genvar gi = 0; gi < P_NRALUOP; gi++) begin : g_fu
            logic [ENTRY_W-1:0] fifo_dout;

            // Ready looks at occupancy only, never at a same-cycle pop.
            assign fu_ready[gi] = ~fifo_full[gi] & ~rst;
            assign push[gi]     = fu_valid[gi] & fu_ready[gi];
            assign pop[gi]      = grant_valid && (grant_idx == P_FU_W'(gi));

            result_fifo #(
                .DEPTH (P_BUF_DEPTH),
                .WIDTH (ENTRY_W)
            ) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .push  (push[gi]),
                .pop   (pop[gi]),
                .din   ({fu_tag[gi], fu_data[gi]}),
                .dout  (fifo_dout),
                .empty (fifo_empty[gi]),
                .full  (fifo_full[gi])
            );

            assign head_entry[gi] = entry_t'(fifo_dout);
        end
    endgenerate

    // Round-robin picker: first non-empty FIFO at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < P_NRALUOP; k++) begin
            idx = (int'(rr_ptr_q) + k) % P_NRALUOP;
            if (!grant_valid && !fifo_empty[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = P_FU_W'(idx);
            end
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = 1'b0;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        cdb_fu_d    = cdb_fu_q;
        if (grant_valid) begin
            cdb_valid_d = 1'b1;
            cdb_tag_d   = head_entry[grant_idx].tag;
            cdb_data_d  = head_entry[grant_idx].data;
            cdb_fu_d    = grant_idx;
            rr_ptr_d    = (grant_idx == P_FU_W'(P_NRALUOP - 1)) ? '0
                                                                : grant_idx + P_FU_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_fu_q    <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_fu_q    <= cdb_fu_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_fu    = cdb_fu_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
// Self-checking bench for cdb_arbiter: a directed vector table, hand-written
// multi-cycle sequences and a randomized run, all compared against a
// queue-based reference model of the result buffers and round-robin grant.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

    localparam int N     = 8;
    localparam int TW    = 6;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic                   clk;
    logic                   rst;
    logic [N-1:0]           fu_valid;
    logic [N-1:0][TW-1:0]   fu_tag;
    logic [N-1:0][DW-1:0]   fu_data;
    logic [N-1:0]           fu_ready;
    logic                   cdb_valid;
    logic [TW-1:0]          cdb_tag;
    logic [DW-1:0]          cdb_data;
    logic [2:0]             cdb_fu;

    cdb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .fu_valid  (fu_valid),
        .fu_tag    (fu_tag),
        .fu_data   (fu_data),
        .fu_ready  (fu_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_fu    (cdb_fu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          mq [N][$];
    int            m_rr;
    logic          m_valid;
    logic [2:0]    m_fu;
    logic [TW-1:0] m_tag;
    logic [DW-1:0] m_data;

    // ---------------- FU drivers ----------------
    logic          cur_valid [N];
    logic [TW-1:0] cur_tag   [N];
    logic [DW-1:0] cur_data  [N];
    logic [N-1:0]  acc;
    logic [N-1:0]  obs_ready;
    bit            verbose;

    int checks;
    int errors;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void new_result(input int i);
        cur_tag[i]  = {3'(i), 3'($urandom_range(0, 7))};
        cur_data[i] = $urandom;
    endfunction

    // One clock cycle: drive, check ready, advance model, check CDB.
    task automatic step(input logic r);
        logic [N-1:0] mready;
        int g;
        ent_t e;
        rst = r;
        for (int i = 0; i < N; i++) begin
            fu_valid[i] = cur_valid[i];
            fu_tag[i]   = cur_tag[i];
            fu_data[i]  = cur_data[i];
        end
        #1;
        for (int i = 0; i < N; i++)
            mready[i] = !r && (mq[i].size() != DEPTH);
        obs_ready = fu_ready;
        chk("fu_ready", 64'(fu_ready), 64'(mready));
        acc = fu_valid & mready;
        if (r) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_rr = 0; m_valid = 0; m_fu = 0; m_tag = 0; m_data = 0;
        end else begin
            g = -1;
            for (int k = 0; k < N; k++)
                if (g < 0 && mq[(m_rr + k) % N].size() > 0) g = (m_rr + k) % N;
            if (g >= 0) begin
                e = mq[g].pop_front();
                m_valid = 1; m_fu = 3'(g); m_tag = e.tag; m_data = e.data;
                m_rr = (g + 1) % N;
            end else begin
                m_valid = 0;
            end
            for (int i = 0; i < N; i++)
                if (acc[i]) mq[i].push_back('{tag: cur_tag[i], data: cur_data[i]});
        end
        @(posedge clk);
        #1;
        chk("cdb", 64'({cdb_valid, cdb_fu, cdb_tag, cdb_data}),
                   64'({m_valid, m_fu, m_tag, m_data}));
        if (verbose && cdb_valid)
            $display("cdb: fu=%0d tag=%h data=%h", cdb_fu, cdb_tag, cdb_data);
    endtask

    function automatic void idle_all();
        for (int i = 0; i < N; i++) begin
            cur_valid[i] = 0; cur_tag[i] = '0; cur_data[i] = '0;
        end
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          rst;
        logic [N-1:0]  valid;
        logic [2:0]    slot;
        logic [DW-1:0] base;
        logic [N-1:0]  exp_ready;
        logic          exp_valid;
        logic [2:0]    exp_fu;
        logic [TW-1:0] exp_tag;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t tbl [13];

    int grant_log [$];
    int gcount [N];
    int bad_seq;
    int fu1_sent;
    int fu1_seen;
    int pulses;

    initial begin
        checks = 0; errors = 0; verbose = 1; m_rr = 0;
        m_valid = 0; m_fu = 0; m_tag = 0; m_data = 0;
        idle_all();
        rst = 1; fu_valid = '0; fu_tag = '0; fu_data = '0;

        //            rst valid  slot base          ready  v  fu  tag    data
        tbl[0]  = '{1'b1, 8'hFF, 3'd0, 32'h0,        8'h00, 1'b0, 3'd0, 6'h00, 32'h0};
        tbl[1]  = '{1'b1, 8'hFF, 3'd0, 32'h0,        8'h00, 1'b0, 3'd0, 6'h00, 32'h0};
        tbl[2]  = '{1'b1, 8'hFF, 3'd0, 32'h0,        8'h00, 1'b0, 3'd0, 6'h00, 32'h0};
        tbl[3]  = '{1'b0, 8'h00, 3'd0, 32'h0,        8'hFF, 1'b0, 3'd0, 6'h00, 32'h0};
        tbl[4]  = '{1'b0, 8'h08, 3'd2, 32'hDEADBEEC, 8'hFF, 1'b0, 3'd0, 6'h00, 32'h0};
        tbl[5]  = '{1'b0, 8'h00, 3'd0, 32'h0,        8'hFF, 1'b1, 3'd3, 6'h1A, 32'hDEADBEEF};
        tbl[6]  = '{1'b0, 8'h00, 3'd0, 32'h0,        8'hFF, 1'b0, 3'd3, 6'h1A, 32'hDEADBEEF};
        tbl[7]  = '{1'b1, 8'h00, 3'd0, 32'h0,        8'h00, 1'b0, 3'd0, 6'h00, 32'h0};
        tbl[8]  = '{1'b0, 8'h85, 3'd1, 32'h10000000, 8'hFF, 1'b0, 3'd0, 6'h00, 32'h0};
        tbl[9]  = '{1'b0, 8'h00, 3'd0, 32'h0,        8'hFF, 1'b1, 3'd0, 6'h01, 32'h10000000};
        tbl[10] = '{1'b0, 8'h00, 3'd0, 32'h0,        8'hFF, 1'b1, 3'd2, 6'h11, 32'h10000002};
        tbl[11] = '{1'b0, 8'h00, 3'd0, 32'h0,        8'hFF, 1'b1, 3'd7, 6'h39, 32'h10000007};
        tbl[12] = '{1'b0, 8'h00, 3'd0, 32'h0,        8'hFF, 1'b0, 3'd7, 6'h39, 32'h10000007};

        for (int v = 0; v < 13; v++) begin
            for (int i = 0; i < N; i++) begin
                cur_valid[i] = tbl[v].valid[i];
                cur_tag[i]   = {3'(i), tbl[v].slot};
                cur_data[i]  = tbl[v].base + DW'(i);
            end
            step(tbl[v].rst);
            chk("tbl_ready", 64'(obs_ready), 64'(tbl[v].exp_ready));
            chk("tbl_cdb", 64'({cdb_valid, cdb_fu, cdb_tag, cdb_data}),
                64'({tbl[v].exp_valid, tbl[v].exp_fu, tbl[v].exp_tag, tbl[v].exp_data}));
            $display("vec %0d: rst=%b valid=%h ready=%h cdb_v=%b fu=%0d tag=%h data=%h",
                     v, tbl[v].rst, tbl[v].valid, obs_ready, cdb_valid, cdb_fu, cdb_tag, cdb_data);
        end

        // ---------------- full FIFO: FU1 three results, FU0 streaming ----------------
        idle_all();
        step(1'b1);
        fu1_sent = 0; fu1_seen = 0;
        cur_valid[0] = 1; new_result(0);
        cur_valid[1] = 1; new_result(1);
        for (int c = 0; c < 12; c++) begin
            step(1'b0);
            if (c == 2) chk("fu1_full_ready", 64'(obs_ready[1]), 64'(0));
            if (cdb_valid && cdb_fu == 3'd1) fu1_seen++;
            if (acc[0]) new_result(0);
            if (acc[1]) begin
                fu1_sent++;
                if (fu1_sent < 3) new_result(1);
                else cur_valid[1] = 0;
            end
        end
        chk("fu1_broadcasts", 64'(fu1_seen), 64'(3));

        // ---------------- fairness: all FUs continuously valid ----------------
        idle_all();
        step(1'b1);
        verbose = 0;
        for (int i = 0; i < N; i++) begin
            cur_valid[i] = 1; new_result(i); gcount[i] = 0;
        end
        grant_log.delete();
        for (int c = 0; c < 66; c++) begin
            step(1'b0);
            if (cdb_valid) grant_log.push_back(int'(cdb_fu));
            for (int i = 0; i < N; i++) if (acc[i]) new_result(i);
        end
        bad_seq = 0;
        for (int k = 0; k < 64 && k < grant_log.size(); k++) begin
            gcount[grant_log[k]]++;
            if (grant_log[k] != k % N) bad_seq++;
        end
        chk("fair_grants", 64'(grant_log.size() >= 64), 64'(1));
        chk("fair_sequence", 64'(bad_seq), 64'(0));
        for (int i = 0; i < N; i++) chk("fair_count", 64'(gcount[i]), 64'(8));
        $display("fairness: %0d grants logged", grant_log.size());
        verbose = 1;

        // ---------------- reset mid-operation ----------------
        idle_all();
        step(1'b1);
        for (int i = 4; i < N; i++) begin cur_valid[i] = 1; new_result(i); end
        step(1'b0);
        idle_all();
        step(1'b1);
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            step(1'b0);
            if (c == 0) chk("midrst_ready", 64'(obs_ready), 64'(8'hFF));
            if (cdb_valid) pulses++;
        end
        chk("midrst_pulses", 64'(pulses), 64'(0));

        // ---------------- randomized run ----------------
        verbose = 0;
        idle_all();
        step(1'b1);
        for (int c = 0; c < 3000; c++) begin
            int load;
            load = (c < 1500) ? 30 : 90;
            for (int i = 0; i < N; i++) begin
                if (!cur_valid[i] || acc[i]) begin
                    cur_valid[i] = ($urandom_range(0, 99) < load);
                    if (cur_valid[i]) new_result(i);
                end
            end
            step($urandom_range(0, 249) == 0);
        end
        $display("random: done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
